// File: rtl/ula_pkg.sv
// Shared types, function-select codes and the bitwise function table for the ULA family.
package ula_pkg;

    typedef logic [3:0] ula_sel_t;

    localparam ula_sel_t ARITH_INC        = 4'b0000;
    localparam ula_sel_t ARITH_ADD        = 4'b0101;
    localparam ula_sel_t ARITH_SUB        = 4'b1000;
    localparam ula_sel_t ARITH_DBL        = 4'b1100;
    localparam ula_sel_t ARITH_DEC        = 4'b1111;

    localparam ula_sel_t LOGIC_NOT_A      = 4'b0000;
    localparam ula_sel_t LOGIC_NOR        = 4'b0001;
    localparam ula_sel_t LOGIC_NOTA_AND_B = 4'b0010;
    localparam ula_sel_t LOGIC_ZERO       = 4'b0011;
    localparam ula_sel_t LOGIC_NAND       = 4'b0100;
    localparam ula_sel_t LOGIC_NOT_B      = 4'b0101;
    localparam ula_sel_t LOGIC_XOR        = 4'b0110;
    localparam ula_sel_t LOGIC_A_AND_NOTB = 4'b0111;
    localparam ula_sel_t LOGIC_NOTA_OR_B  = 4'b1000;
    localparam ula_sel_t LOGIC_XNOR       = 4'b1001;
    localparam ula_sel_t LOGIC_B          = 4'b1010;
    localparam ula_sel_t LOGIC_AND        = 4'b1011;
    localparam ula_sel_t LOGIC_ONE        = 4'b1100;
    localparam ula_sel_t LOGIC_A_OR_NOTB  = 4'b1101;
    localparam ula_sel_t LOGIC_OR         = 4'b1110;
    localparam ula_sel_t LOGIC_A          = 4'b1111;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
        logic eq;
    } ula_flags_t;

    // Only SUB treats carry as an inverted borrow; DEC chains with the carry as-is.
    function automatic logic is_sub_class(input ula_sel_t s);
        return (s == ARITH_SUB);
    endfunction

    function automatic logic [3:0] logic_fn4(input ula_sel_t s, input logic [3:0] x,
                                             input logic [3:0] y);
        logic [3:0] r;
        case (s)
            LOGIC_NOT_A:      r = ~x;
            LOGIC_NOR:        r = ~(x | y);
            LOGIC_NOTA_AND_B: r = ~x & y;
            LOGIC_ZERO:       r = '0;
            LOGIC_NAND:       r = ~(x & y);
            LOGIC_NOT_B:      r = ~y;
            LOGIC_XOR:        r = x ^ y;
            LOGIC_A_AND_NOTB: r = x & ~y;
            LOGIC_NOTA_OR_B:  r = ~x | y;
            LOGIC_XNOR:       r = ~(x ^ y);
            LOGIC_B:          r = y;
            LOGIC_AND:        r = x & y;
            LOGIC_ONE:        r = '1;
            LOGIC_A_OR_NOTB:  r = x | ~y;
            LOGIC_OR:         r = x | y;
            default:          r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ula_nucleo.sv
// Combinational ULA core: WIDTH/4 ripple-cascaded 4-bit slices sharing one operand-B preparation.
module ula_nucleo
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  ula_sel_t         s_i,
    input  logic             m_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] f_o,
    output logic             c_o,
    output logic             v_o,
    output logic             eq_o
);

    localparam int unsigned NS = WIDTH / 4;

    logic [WIDTH-1:0] opb;
    logic             ci;
    logic             arith_op;
    logic [NS:0]      carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] lres;

    always_comb begin
        opb      = '0;
        ci       = 1'b0;
        arith_op = 1'b1;
        case (s_i)
            ARITH_ADD: begin opb = b_i;  ci = cin_i;  end
            ARITH_SUB: begin opb = ~b_i; ci = ~cin_i; end
            ARITH_INC: begin opb = '0;   ci = cin_i;  end
            ARITH_DEC: begin opb = '1;   ci = cin_i;  end
            ARITH_DBL: begin opb = a_i;  ci = cin_i;  end
            default:   arith_op = 1'b0;
        endcase
    end

    assign carry[0] = ci;

    for (genvar g = 0; g < NS; g++) begin : g_slice
        logic [4:0] sum4;
        assign sum4 = {1'b0, a_i[4*g+3 -: 4]} + {1'b0, opb[4*g+3 -: 4]} + {4'b0000, carry[g]};
        assign sum[4*g+3 -: 4]  = sum4[3:0];
        assign carry[g+1]       = sum4[4];
        assign lres[4*g+3 -: 4] = logic_fn4(s_i, a_i[4*g+3 -: 4], b_i[4*g+3 -: 4]);
    end

    assign f_o  = m_i ? lres : (arith_op ? sum : a_i);
    assign c_o  = !m_i && arith_op && carry[NS];
    assign v_o  = !m_i && arith_op && (a_i[WIDTH-1] == opb[WIDTH-1])
                                   && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/ula_n_bits_pipe.sv
// Registered ULA with valid/ready handshake, flag register, accumulator operand and carry chaining.
module ula_n_bits_pipe
    import ula_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    input  logic             use_acc,
    input  logic             chain,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             a_eq_b,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] acc
);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("ula_n_bits_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    ula_flags_t       flags_q, flags_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] a_eff;
    logic             cin_eff;
    logic             accept;
    logic [WIDTH-1:0] core_f;
    logic             core_c, core_v, core_eq;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign a_eff    = use_acc ? acc_q : a;
    assign cin_eff  = chain ? (is_sub_class(s) ? ~flags_q.c : flags_q.c) : c_in;

    ula_nucleo #(.WIDTH(WIDTH)) u_nucleo (
        .a_i   (a_eff),
        .b_i   (b),
        .s_i   (s),
        .m_i   (m),
        .cin_i (cin_eff),
        .f_o   (core_f),
        .c_o   (core_c),
        .v_o   (core_v),
        .eq_o  (core_eq)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        if (accept) begin
            out_valid_d = 1'b1;
            f_d         = core_f;
            acc_d       = core_f;
            flags_d.c   = core_c;
            flags_d.v   = core_v;
            flags_d.z   = (core_f == '0);
            flags_d.n   = core_f[WIDTH-1];
            flags_d.eq  = core_eq;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // Setting beats clearing when both happen in the same cycle.
        if (accept && core_v) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            flags_q     <= '0;
            acc_q       <= ACC_RESET;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign f          = f_q;
    assign c_out      = flags_q.c;
    assign overflow   = flags_q.v;
    assign zero       = flags_q.z;
    assign negative   = flags_q.n;
    assign a_eq_b     = flags_q.eq;
    assign ovf_sticky = sticky_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_ula_n_bits_pipe.sv
// Directed, table-driven bench for ula_n_bits_pipe at WIDTH=8 plus a WIDTH=32 instance.
module tb_ula_n_bits_pipe;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] s;
        logic       m;
        logic       cin;
        logic       ua;
        logic       ch;
        logic [7:0] ef;
        logic       ec;
        logic       ev;
        logic       ez;
        logic       en;
        logic       eq;
    } vec_t;

    localparam int NV = 36;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_valid32;
    logic       out_ready;
    logic [3:0] s;
    logic       m, c_in, use_acc, chain, clr_sticky;
    logic [7:0] a, b;
    logic       in_ready, out_valid, c_out, overflow, zero, negative, a_eq_b, ovf_sticky;
    logic [7:0] f, acc;

    logic [31:0] a32, b32, f32, acc32;
    logic        in_ready32, out_valid32, c_out32, overflow32, zero32, negative32;
    logic        a_eq_b32, ovf_sticky32;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[NV];
    logic sticky_exp;

    always #5 clk = ~clk;

    ula_n_bits_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .m(m), .c_in(c_in), .use_acc(use_acc), .chain(chain),
        .clr_sticky(clr_sticky), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .c_out(c_out), .overflow(overflow), .zero(zero), .negative(negative),
        .a_eq_b(a_eq_b), .ovf_sticky(ovf_sticky), .acc(acc)
    );

    ula_n_bits_pipe #(.WIDTH(32), .ACC_RESET(32'h1234_5678)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .s(s), .m(m), .c_in(c_in), .use_acc(use_acc), .chain(chain),
        .clr_sticky(clr_sticky), .out_valid(out_valid32), .out_ready(out_ready),
        .f(f32), .c_out(c_out32), .overflow(overflow32), .zero(zero32),
        .negative(negative32), .a_eq_b(a_eq_b32), .ovf_sticky(ovf_sticky32), .acc(acc32)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vs,
                                input logic vm, input logic vcin, input logic vua,
                                input logic vch, input logic [7:0] vf, input logic vc,
                                input logic vv, input logic vz, input logic vn,
                                input logic veq);
        vec_t v;
        v.a = va; v.b = vb; v.s = vs; v.m = vm; v.cin = vcin; v.ua = vua; v.ch = vch;
        v.ef = vf; v.ec = vc; v.ev = vv; v.ez = vz; v.en = vn; v.eq = veq;
        return v;
    endfunction

    task automatic op8(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vs,
                       input logic vm, input logic vcin, input logic vua, input logic vch);
        a = va; b = vb; s = vs; m = vm; c_in = vcin; use_acc = vua; chain = vch;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_flags(input string nm, input logic [7:0] ef, input logic ec,
                             input logic ev, input logic ez, input logic en, input logic eq);
        chk({nm, ".f"}, {24'd0, f}, {24'd0, ef});
        chk({nm, ".c"}, {31'd0, c_out}, {31'd0, ec});
        chk({nm, ".v"}, {31'd0, overflow}, {31'd0, ev});
        chk({nm, ".z"}, {31'd0, zero}, {31'd0, ez});
        chk({nm, ".n"}, {31'd0, negative}, {31'd0, en});
        chk({nm, ".eq"}, {31'd0, a_eq_b}, {31'd0, eq});
    endtask

    initial begin
        // a, b, s, m, cin, use_acc, chain | f, c, v, z, n, eq
        tbl[0]  = mk(8'h7F, 8'h01, 4'b0101, 0, 0, 0, 0, 8'h80, 0, 1, 0, 1, 0);
        tbl[1]  = mk(8'hFF, 8'h01, 4'b0101, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[2]  = mk(8'h00, 8'h00, 4'b0101, 0, 0, 0, 1, 8'h01, 0, 0, 0, 0, 1);
        tbl[3]  = mk(8'hFF, 8'h01, 4'b0101, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[4]  = mk(8'h77, 8'h00, 4'b0101, 0, 0, 1, 1, 8'h01, 0, 0, 0, 0, 1);
        tbl[5]  = mk(8'h0A, 8'h05, 4'b1000, 0, 0, 0, 0, 8'h05, 1, 0, 0, 0, 0);
        tbl[6]  = mk(8'h05, 8'h0A, 4'b1000, 0, 0, 0, 0, 8'hFB, 0, 0, 0, 1, 0);
        tbl[7]  = mk(8'h80, 8'h01, 4'b1000, 0, 0, 0, 0, 8'h7F, 1, 1, 0, 0, 0);
        tbl[8]  = mk(8'h10, 8'h01, 4'b1000, 0, 1, 0, 1, 8'h0F, 1, 0, 0, 0, 0);
        tbl[9]  = mk(8'h10, 8'h01, 4'b1000, 0, 1, 0, 0, 8'h0E, 1, 0, 0, 0, 0);
        tbl[10] = mk(8'h00, 8'h01, 4'b1000, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 1, 0);
        tbl[11] = mk(8'h05, 8'h00, 4'b1000, 0, 0, 0, 1, 8'h04, 1, 0, 0, 0, 0);
        tbl[12] = mk(8'h41, 8'h00, 4'b0000, 0, 1, 0, 0, 8'h42, 0, 0, 0, 0, 0);
        tbl[13] = mk(8'hFF, 8'h00, 4'b0000, 0, 1, 0, 0, 8'h00, 1, 0, 1, 0, 0);
        tbl[14] = mk(8'h00, 8'h00, 4'b1111, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 1, 1);
        tbl[15] = mk(8'h05, 8'h01, 4'b1111, 0, 1, 0, 0, 8'h05, 1, 0, 0, 0, 0);
        tbl[16] = mk(8'h40, 8'h00, 4'b1100, 0, 0, 0, 0, 8'h80, 0, 1, 0, 1, 0);
        tbl[17] = mk(8'h81, 8'h00, 4'b1100, 0, 1, 0, 0, 8'h03, 1, 1, 0, 0, 0);
        tbl[18] = mk(8'h3C, 8'h11, 4'b0001, 0, 1, 0, 0, 8'h3C, 0, 0, 0, 0, 0);
        tbl[19] = mk(8'hC3, 8'hA5, 4'b1011, 1, 1, 0, 1, 8'h81, 0, 0, 0, 1, 0);
        tbl[20] = mk(8'hC3, 8'hA5, 4'b1110, 1, 1, 0, 0, 8'hE7, 0, 0, 0, 1, 0);
        tbl[21] = mk(8'hC3, 8'hA5, 4'b0110, 1, 0, 0, 1, 8'h66, 0, 0, 0, 0, 0);
        tbl[22] = mk(8'hC3, 8'hA5, 4'b1001, 1, 0, 0, 0, 8'h99, 0, 0, 0, 1, 0);
        tbl[23] = mk(8'hC3, 8'hA5, 4'b0000, 1, 1, 0, 0, 8'h3C, 0, 0, 0, 0, 0);
        tbl[24] = mk(8'hC3, 8'hA5, 4'b0001, 1, 0, 0, 0, 8'h18, 0, 0, 0, 0, 0);
        tbl[25] = mk(8'hC3, 8'hA5, 4'b0011, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        tbl[26] = mk(8'hC3, 8'hA5, 4'b1100, 1, 0, 0, 0, 8'hFF, 0, 0, 0, 1, 0);
        tbl[27] = mk(8'hC3, 8'hA5, 4'b1111, 1, 0, 0, 0, 8'hC3, 0, 0, 0, 1, 0);
        tbl[28] = mk(8'hC3, 8'hA5, 4'b1010, 1, 0, 0, 0, 8'hA5, 0, 0, 0, 1, 0);
        tbl[29] = mk(8'hC3, 8'hA5, 4'b0100, 1, 0, 0, 0, 8'h7E, 0, 0, 0, 0, 0);
        tbl[30] = mk(8'hC3, 8'hA5, 4'b0010, 1, 0, 0, 0, 8'h24, 0, 0, 0, 0, 0);
        tbl[31] = mk(8'hC3, 8'hA5, 4'b0111, 1, 0, 0, 0, 8'h42, 0, 0, 0, 0, 0);
        tbl[32] = mk(8'hC3, 8'hA5, 4'b1000, 1, 0, 0, 0, 8'hBD, 0, 0, 0, 1, 0);
        tbl[33] = mk(8'hC3, 8'hA5, 4'b1101, 1, 0, 0, 0, 8'hDB, 0, 0, 0, 1, 0);
        tbl[34] = mk(8'hC3, 8'hA5, 4'b0101, 1, 0, 0, 0, 8'h5A, 0, 0, 0, 0, 0);
        tbl[35] = mk(8'h55, 8'h55, 4'b1011, 1, 0, 0, 0, 8'h55, 0, 0, 0, 0, 1);

        rst_n = 1'b0; in_valid = 1'b0; in_valid32 = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0; use_acc = 1'b0; chain = 1'b0;
        clr_sticky = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk_flags("rst", 8'h00, 0, 0, 0, 0, 0);
        chk("rst.sticky", {31'd0, ovf_sticky}, 32'd0);
        chk("rst.acc", {24'd0, acc}, 32'd0);
        chk("rst.acc32", acc32, 32'h1234_5678);

        sticky_exp = 1'b0;
        for (int i = 0; i < NV; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cin, tbl[i].ua, tbl[i].ch);
            sticky_exp = sticky_exp | tbl[i].ev;
            chk_flags($sformatf("v%0d", i), tbl[i].ef, tbl[i].ec, tbl[i].ev, tbl[i].ez,
                      tbl[i].en, tbl[i].eq);
            chk($sformatf("v%0d.acc", i), {24'd0, acc}, {24'd0, tbl[i].ef});
            chk($sformatf("v%0d.ovalid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d.sticky", i), {31'd0, ovf_sticky}, {31'd0, sticky_exp});
        end

        // Sticky: plain clear, clear+overflow (set wins), clear+clean op.
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        chk("stk.clear", {31'd0, ovf_sticky}, 32'd0);
        chk("stk.idle_ovalid", {31'd0, out_valid}, 32'd0);
        op8(8'h7F, 8'h01, 4'b0101, 0, 0, 0, 0);
        chk("stk.setwins", {31'd0, ovf_sticky}, 32'd1);
        op8(8'h01, 8'h01, 4'b0101, 0, 0, 0, 0);
        chk("stk.clr_accept", {31'd0, ovf_sticky}, 32'd0);
        clr_sticky = 1'b0;

        // Backpressure: one pending result, second request held for 3 cycles.
        op8(8'h10, 8'h20, 4'b0101, 0, 0, 0, 0);
        chk("bp.f0", {24'd0, f}, 32'h30);
        out_ready = 1'b0;
        a = 8'hEE; b = 8'h01; s = 4'b0101; use_acc = 1'b1; in_valid = 1'b1;
        #1;
        chk("bp.in_ready0", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.c%0d.in_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp.c%0d.f", k), {24'd0, f}, 32'h30);
            chk($sformatf("bp.c%0d.ovalid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp.c%0d.acc", k), {24'd0, acc}, 32'h30);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready1", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; use_acc = 1'b0;
        chk("bp.f1", {24'd0, f}, 32'h31);
        chk("bp.ovalid1", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("bp.drain", {31'd0, out_valid}, 32'd0);
        chk("bp.one_accept", {24'd0, acc}, 32'h31);

        // Reset while a result is pending.
        out_ready = 1'b0;
        op8(8'hFF, 8'hFF, 4'b0101, 0, 1, 0, 0);
        chk("rr.pending", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        chk("rr.ovalid", {31'd0, out_valid}, 32'd0);
        chk("rr.acc", {24'd0, acc}, 32'd0);
        chk_flags("rr", 8'h00, 0, 0, 0, 0, 0);

        // Accumulate from reset; a is ignored while use_acc=1.
        op8(8'hEE, 8'h03, 4'b0101, 0, 0, 1, 0);
        chk("acc.f1", {24'd0, f}, 32'h03);
        op8(8'hEE, 8'h03, 4'b0101, 0, 0, 1, 0);
        chk("acc.f2", {24'd0, f}, 32'h06);
        op8(8'hEE, 8'h03, 4'b0101, 0, 0, 1, 0);
        chk("acc.f3", {24'd0, f}, 32'h09);
        chk("acc.acc", {24'd0, acc}, 32'h09);
        op8(8'h55, 8'h55, 4'b1011, 1, 0, 0, 0);
        chk_flags("acc.and", 8'h55, 0, 0, 0, 0, 1);

        // WIDTH=32 instance.
        chk("w32.acc_rst", acc32, 32'h1234_5678);
        a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; s = 4'b0101; m = 1'b0; c_in = 1'b0;
        use_acc = 1'b0; chain = 1'b0; in_valid32 = 1'b1;
        @(posedge clk); #1;
        chk("w32.f", f32, 32'h8000_0000);
        chk("w32.v", {31'd0, overflow32}, 32'd1);
        chk("w32.n", {31'd0, negative32}, 32'd1);
        chk("w32.c", {31'd0, c_out32}, 32'd0);
        a32 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        chk("w32.wrap.f", f32, 32'h0000_0000);
        chk("w32.wrap.c", {31'd0, c_out32}, 32'd1);
        chk("w32.wrap.z", {31'd0, zero32}, 32'd1);
        chk("w32.acc", acc32, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
